regfile_write_scheduler: RTL and testbench
==========================================

# regfile_write_scheduler

Write-port scheduler and scoreboard for the 32 x 64-bit register file. It arbitrates the register file's single write port between the ALU writeback path and the load (memory) writeback path, and registers the winning write onto the register file's `wr`/`wdata`/`regWrite` inputs. It also keeps a per-register busy scoreboard, so decode can stall on read-after-write and write-after-write hazards. It sits between execute/memory writeback and the register file, alongside decode.

## Interface
Parameters:
- `XLEN`, 64, data width of a write.
- `NREG`, 32, number of architectural registers.
- `AW`, 5, register index width (log2 `NREG`).

Ports:
- `clock`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `iss_valid`  in  1  decode issues an instruction that will write `iss_rd`.
- `iss_rd`  in  AW  destination register of the issued instruction.
- `iss_stall`  out  1  issue refused this cycle (WAW: `iss_rd` already busy).
- `rs1`, `rs2`  in  AW  source registers of the instruction in decode.
- `raw_hazard`  out  1  `busy[rs1] | busy[rs2]`.
- `alu_valid`  in  1  ALU write request.
- `alu_rd`  in  AW  ALU write destination.
- `alu_data`  in  XLEN  ALU write data.
- `alu_ready`  out  1  ALU request accepted this cycle.
- `mem_valid`  in  1  load write request.
- `mem_rd`  in  AW  load write destination.
- `mem_data`  in  XLEN  load write data.
- `mem_ready`  out  1  load request accepted this cycle.
- `wr`  out  AW  register file write index (registered).
- `wdata`  out  XLEN  register file write data (registered).
- `regWrite`  out  1  register file write enable (registered).
- `busy_count`  out  AW+1  number of busy registers (population count of `busy`).

## Operation
- Scoreboard `busy[NREG-1:0]`. `busy[0]` is hard-wired 0 and never set.
- Issue:
  - `iss_stall = iss_valid & busy[iss_rd]` (combinational).
  - If `iss_valid & !iss_stall & iss_rd != 0`, `busy[iss_rd]` is set at the posedge.
  - A stalled issue changes no state.
- Arbitration:
  - Combinational, round-robin, with a 1-bit `last` state (0 = ALU was granted last).
  - Only one requester valid: that requester is granted.
  - Both valid: the one not granted last wins.
  - `last` updates only on a grant.
  - `alu_ready`/`mem_ready` equal the grants, at most one high per cycle. A request is accepted on the cycle `valid & ready`.
  - The requester holds `valid`, `rd` and `data` stable until accepted.
- Write stage:
  - On accept with `rd != 0`: at that posedge, `wr <= rd`, `wdata <= data`, `regWrite <= 1`.
  - With no accept, or an accept with `rd == 0`: `regWrite <= 0`. `wr`/`wdata` hold their previous values.
  - An x0 write is consumed (ready asserted) but never reaches the register file.
- Busy clear: at each posedge where `regWrite == 1`, `busy[wr]` is cleared. That is the same edge on which the register file commits the data.
- Set/clear on the same register at the same edge (issue of `rd` while `regWrite` for `rd` is high): set wins.
- A write request to a register that is not busy is performed normally. The scoreboard is unaffected.

## Timing
- Reset (async, immediate):
  - `busy = 0`, `last = 1` (ALU wins the first conflict).
  - `regWrite = 0`, `wr = 0`, `wdata = 0`.
  - `busy_count = 0`, `raw_hazard = 0`, `iss_stall = 0`.
- An in-flight registered write is dropped by reset: it is never committed.
- Latency:
  - Accept at posedge N: `regWrite` is high during cycle N..N+1, and the register file commits at posedge N+1.
  - `busy[rd]` clears at posedge N+1.
  - `raw_hazard` falls in the cycle after N+1. The register file's negedge read in that cycle returns the new value.
- Back-to-back accepts every cycle are supported: throughput of one write per clock.
- `raw_hazard`, `iss_stall`, `alu_ready` and `mem_ready` are combinational from current state and inputs. No other output is combinational.

## Structure
- Shared package `regfile_pkg`:
  - constants `XLEN = 64`, `NREG = 32`, `AW = 5`, `REG_ZERO = 5'd0`;
  - a `wr_req_t` struct `{valid, rd, data}`.
- One natural sub-module: `rr_arbiter2`, the 2-way round-robin grant with its `last` flop. The scoreboard and write stage stay in the top.

## Test plan
- Reset mid-write: accept an ALU write of x5 = 0x1234, then assert `reset` before the next posedge -> `regWrite` goes 0 immediately; x5 is never written; `busy = 0`.
- Single ALU write: issue x3, then ALU writes x3 = 0xDEAD_BEEF -> `alu_ready` high 1 cycle; `regWrite`/`wr = 3`/`wdata = 0xDEADBEEF` one cycle later; `raw_hazard` for `rs1 = 3` high from issue until the cycle after commit.
- Conflict: ALU (x1 = 0x11) and load (x2 = 0x22) both valid for 3 cycles after reset, each re-presenting after acceptance -> grants ALU, load, ALU. Commit order x1, x2, x1.
- x0 write: load to x0 with data 0xFF -> `mem_ready = 1`; `regWrite` stays 0; `busy_count` unchanged.
- WAW stall: issue x7, then issue x7 again before its write -> second issue gets `iss_stall = 1`; `busy_count` stays 1.
- Same-edge set/clear: x4 is committing (`regWrite = 1`, `wr = 4`) while a new issue of x4 is made on that edge -> `busy[4]` remains 1; `busy_count` unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and write-request type for the register file write path
package regfile_pkg;
   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam int AW = 5;
   localparam logic [AW-1:0] REG_ZERO = 5'd0;
   typedef struct packed {
      logic            valid;
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] data;
   } wr_req_t;
endpackage

// File: rtl/regfile_write_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; last = 1 means requester b was granted last
module rr_arbiter2 (
   input  logic clock,
   input  logic reset,
   input  logic req_a,
   input  logic req_b,
   output logic gnt_a,
   output logic gnt_b
);
   logic last;
   assign gnt_a = req_a & (~req_b | last);
   assign gnt_b = req_b & (~req_a | ~last);
   always_ff @(posedge clock or posedge reset)
      if (reset) last <= 1'b1;
      else if (gnt_a | gnt_b) last <= gnt_b;
endmodule

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: arbitrates ALU/load writeback onto the register file write port and tracks busy registers
module regfile_write_scheduler #(
   parameter int XLEN = regfile_pkg::XLEN,
   parameter int NREG = regfile_pkg::NREG,
   parameter int AW = regfile_pkg::AW
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   output logic            iss_stall,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic            raw_hazard,
   input  logic            alu_valid,
   input  logic [AW-1:0]   alu_rd,
   input  logic [XLEN-1:0] alu_data,
   output logic            alu_ready,
   input  logic            mem_valid,
   input  logic [AW-1:0]   mem_rd,
   input  logic [XLEN-1:0] mem_data,
   output logic            mem_ready,
   output logic [AW-1:0]   wr,
   output logic [XLEN-1:0] wdata,
   output logic            regWrite,
   output logic [AW:0]     busy_count
);
   import regfile_pkg::*;
   logic [NREG-1:0] busy, set_mask, clr_mask;
   wr_req_t alu_req, mem_req, win;
   assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
   assign mem_req = '{valid: mem_valid, rd: mem_rd, data: mem_data};
   rr_arbiter2 u_arb (
      .clock (clock),
      .reset (reset),
      .req_a (alu_valid),
      .req_b (mem_valid),
      .gnt_a (alu_ready),
      .gnt_b (mem_ready)
   );
   assign win = mem_ready ? mem_req : alu_req;
   assign iss_stall = iss_valid & busy[iss_rd];
   assign raw_hazard = busy[rs1] | busy[rs2];
   // set is applied after clear so a same-edge reissue keeps the register busy
   assign set_mask = (iss_valid & ~iss_stall & (iss_rd != REG_ZERO)) ? NREG'(1) << iss_rd : '0;
   assign clr_mask = regWrite ? NREG'(1) << wr : '0;
   always_ff @(posedge clock or posedge reset)
      if (reset) busy <= '0;
      else busy <= ((busy & ~clr_mask) | set_mask) & ~NREG'(1);
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         regWrite <= 1'b0;
         wr <= '0;
         wdata <= '0;
      end else if ((alu_ready | mem_ready) && win.rd != REG_ZERO) begin
         regWrite <= 1'b1;
         wr <= win.rd;
         wdata <= win.data;
      end else regWrite <= 1'b0;
   always_comb begin
      busy_count = '0;
      for (int i = 0; i < NREG; i++) busy_count = busy_count + (AW+1)'(busy[i]);
   end
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb_regfile_write_scheduler: directed stimulus checked cycle-by-cycle against a scoreboard model
module tb_regfile_write_scheduler;
   logic        clock = 0, reset = 0;
   logic        iss_valid = 0, alu_valid = 0, mem_valid = 0;
   logic [4:0]  iss_rd = 0, rs1 = 0, rs2 = 0, alu_rd = 0, mem_rd = 0;
   logic [63:0] alu_data = 0, mem_data = 0;
   logic        iss_stall, raw_hazard, alu_ready, mem_ready, regWrite;
   logic [4:0]  wr;
   logic [63:0] wdata;
   logic [5:0]  busy_count;
   int checks = 0, errors = 0;

   regfile_write_scheduler dut (
      .clock(clock), .reset(reset), .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_stall(iss_stall),
      .rs1(rs1), .rs2(rs2), .raw_hazard(raw_hazard),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .wr(wr), .wdata(wdata), .regWrite(regWrite), .busy_count(busy_count)
   );

   always #5 clock = ~clock;

   // model: set of outstanding destinations, pending register-file write, who was served last
   bit        mbusy [32];
   bit        last_was_mem = 1;
   bit        m_rw = 0;
   bit [4:0]  m_wr = 0;
   bit [63:0] m_wd = 0;

   function automatic bit exp_alu_gnt();
      if (!alu_valid) return 0;
      if (!mem_valid) return 1;
      return last_was_mem;
   endfunction

   function automatic bit exp_mem_gnt();
      if (!mem_valid) return 0;
      if (!alu_valid) return 1;
      return !last_was_mem;
   endfunction

   function automatic int exp_count();
      int n = 0;
      foreach (mbusy[i]) if (mbusy[i]) n++;
      return n;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         foreach (mbusy[i]) mbusy[i] <= 0;
         last_was_mem <= 1;
         m_rw <= 0;
         m_wr <= 0;
         m_wd <= 0;
      end else begin
         bit ga, gm, stalled;
         ga = exp_alu_gnt();
         gm = exp_mem_gnt();
         stalled = mbusy[iss_rd];
         if (m_rw) mbusy[m_wr] <= 0;
         if (iss_valid && !stalled && iss_rd != 0) mbusy[iss_rd] <= 1;
         if (ga || gm) last_was_mem <= gm;
         if (ga && alu_rd != 0) begin
            m_rw <= 1; m_wr <= alu_rd; m_wd <= alu_data;
         end else if (gm && mem_rd != 0) begin
            m_rw <= 1; m_wr <= mem_rd; m_wd <= mem_data;
         end else m_rw <= 0;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) if (!reset) begin
      chk("iss_stall", 64'(iss_stall), 64'(iss_valid & mbusy[iss_rd]));
      chk("raw_hazard", 64'(raw_hazard), 64'(mbusy[rs1] | mbusy[rs2]));
      chk("alu_ready", 64'(alu_ready), 64'(exp_alu_gnt()));
      chk("mem_ready", 64'(mem_ready), 64'(exp_mem_gnt()));
      chk("regWrite", 64'(regWrite), 64'(m_rw));
      chk("wr", 64'(wr), 64'(m_wr));
      chk("wdata", wdata, m_wd);
      chk("busy_count", 64'(busy_count), 64'(exp_count()));
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #1 reset = 1;
      #1;
      chk("rst_regWrite", 64'(regWrite), 64'd0);
      chk("rst_busy_count", 64'(busy_count), 64'd0);
      chk("rst_wdata", wdata, 64'd0);
      step(); step();
      reset = 0;
      // reset mid-write: accepted x5 write must never commit
      alu_valid = 1; alu_rd = 5; alu_data = 64'h1234;
      #1 chk("t1_alu_ready", 64'(alu_ready), 64'd1);
      step();
      alu_valid = 0;
      #1;
      chk("t1_regWrite_pre", 64'(regWrite), 64'd1);
      chk("t1_wr_pre", 64'(wr), 64'd5);
      reset = 1;
      #1;
      chk("t1_regWrite_rst", 64'(regWrite), 64'd0);
      chk("t1_wr_rst", 64'(wr), 64'd0);
      chk("t1_busy_rst", 64'(busy_count), 64'd0);
      step();
      reset = 0;
      step();
      // single ALU write with RAW window on x3
      iss_valid = 1; iss_rd = 3; rs1 = 3;
      #1 chk("t2_stall", 64'(iss_stall), 64'd0);
      step();
      iss_valid = 0;
      alu_valid = 1; alu_rd = 3; alu_data = 64'hDEAD_BEEF;
      #1;
      chk("t2_raw_set", 64'(raw_hazard), 64'd1);
      chk("t2_alu_ready", 64'(alu_ready), 64'd1);
      step();
      alu_valid = 0;
      #1;
      chk("t2_regWrite", 64'(regWrite), 64'd1);
      chk("t2_wr", 64'(wr), 64'd3);
      chk("t2_wdata", wdata, 64'hDEAD_BEEF);
      chk("t2_raw_hold", 64'(raw_hazard), 64'd1);
      chk("t2_alu_ready_low", 64'(alu_ready), 64'd0);
      step();
      chk("t2_raw_clear", 64'(raw_hazard), 64'd0);
      chk("t2_regWrite_low", 64'(regWrite), 64'd0);
      rs1 = 0;
      // conflict after reset: ALU, load, ALU
      reset = 1;
      #1 reset = 0;
      alu_valid = 1; alu_rd = 1; alu_data = 64'h11;
      mem_valid = 1; mem_rd = 2; mem_data = 64'h22;
      #1;
      chk("t3_g1_alu", 64'(alu_ready), 64'd1);
      chk("t3_g1_mem", 64'(mem_ready), 64'd0);
      step();
      chk("t3_g2_mem", 64'(mem_ready), 64'd1);
      chk("t3_g2_alu", 64'(alu_ready), 64'd0);
      chk("t3_c1_wr", 64'(wr), 64'd1);
      step();
      chk("t3_g3_alu", 64'(alu_ready), 64'd1);
      chk("t3_c2_wr", 64'(wr), 64'd2);
      chk("t3_c2_wdata", wdata, 64'h22);
      step();
      alu_valid = 0; mem_valid = 0;
      #1;
      chk("t3_c3_wr", 64'(wr), 64'd1);
      chk("t3_c3_wdata", wdata, 64'h11);
      step();
      // x0 load is consumed but never written
      mem_valid = 1; mem_rd = 0; mem_data = 64'hFF;
      #1 chk("t4_mem_ready", 64'(mem_ready), 64'd1);
      step();
      mem_valid = 0;
      #1;
      chk("t4_regWrite", 64'(regWrite), 64'd0);
      chk("t4_busy", 64'(busy_count), 64'd0);
      step();
      // WAW stall on x7
      iss_valid = 1; iss_rd = 7;
      step();
      chk("t5_stall", 64'(iss_stall), 64'd1);
      chk("t5_busy", 64'(busy_count), 64'd1);
      step();
      iss_valid = 0;
      #1 chk("t5_busy_hold", 64'(busy_count), 64'd1);
      alu_valid = 1; alu_rd = 7; alu_data = 64'h77;
      step();
      alu_valid = 0;
      step();
      chk("t5_busy_clear", 64'(busy_count), 64'd0);
      // same-edge set/clear on x4: set wins
      alu_valid = 1; alu_rd = 4; alu_data = 64'h44;
      step();
      alu_valid = 0;
      iss_valid = 1; iss_rd = 4; rs2 = 4;
      #1;
      chk("t6_regWrite", 64'(regWrite), 64'd1);
      chk("t6_wr", 64'(wr), 64'd4);
      chk("t6_stall", 64'(iss_stall), 64'd0);
      step();
      iss_valid = 0;
      #1;
      chk("t6_busy", 64'(busy_count), 64'd1);
      chk("t6_raw", 64'(raw_hazard), 64'd1);
      step();
      chk("t6_busy_hold", 64'(busy_count), 64'd1);
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
